round_controller: RTL and testbench

Match sequencer for the two-player light-cycle game. It owns the game-state register and steps through idle, countdown, play, pause, crash hold and match over. It keeps the red and blue round scores and issues the one-cycle `reset_round` pulse that re-initialises bikes and trail memory between rounds. Inputs are the collision logic's crash flags, the start/pause buttons and the ~60 Hz `frame_clk`. Outputs drive the renderer, the score display and the bike/trail reset.

---
 rtl/round_controller.sv | 202 ++++++++++++++++++++
 tb/tb_round_controller.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/round_controller.sv
// round_controller: match sequencer for the two-player light-cycle game.
// Owns game state, round scores and the bike/trail reset pulse.
module round_controller #(
    parameter int WIN_SCORE         = 3,
    parameter int FRAMES_PER_SEC    = 60,
    parameter int COUNTDOWN_SECS    = 3,
    parameter int CRASH_HOLD_FRAMES = 90
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic       red_crash,
    input  logic       blue_crash,
    output logic [2:0] game_state,
    output logic       reset_round,
    output logic [1:0] score_red,
    output logic [1:0] score_blue,
    output logic [1:0] countdown_sec,
    output logic       Red_W,
    output logic       Blue_W,
    output logic       draw_round
);

    localparam int CNT_MAX = (FRAMES_PER_SEC > CRASH_HOLD_FRAMES) ?
                             FRAMES_PER_SEC : CRASH_HOLD_FRAMES;
    localparam int CW = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] SEC_LAST  = CW'(FRAMES_PER_SEC - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(CRASH_HOLD_FRAMES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [1:0]    WIN       = 2'(WIN_SCORE);
    localparam logic [1:0]    CD_INIT   = 2'(COUNTDOWN_SECS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_PLAY  = 3'd2,
        S_PAUSE = 3'd3,
        S_CRASH = 3'd4,
        S_OVER  = 3'd5
    } state_t;

    // Lane 0 frame, lane 1 start, lane 2 pause.
    logic [2:0] sync0_q;
    logic [2:0] sync1_q;
    logic [2:0] prev_q;
    logic [2:0] ev_q;
    logic [2:0] warm_q;
    logic       tick;
    logic       start_ev;
    logic       pause_ev;

    // warm_q masks edges until prev_q holds a post-reset sample,
    // so an input held high through reset release is not an event.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync0_q <= '0;
            sync1_q <= '0;
            prev_q  <= '0;
            ev_q    <= '0;
            warm_q  <= '0;
        end else begin
            sync0_q <= {pause_btn, start_btn, frame_clk};
            sync1_q <= sync0_q;
            prev_q  <= sync1_q;
            warm_q  <= {warm_q[1:0], 1'b1};
            ev_q    <= sync1_q & ~prev_q & {3{warm_q[2]}};
        end
    end

    assign tick     = ev_q[0];
    assign start_ev = ev_q[1];
    assign pause_ev = ev_q[2];

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    cd_q;
    logic [1:0]    red_q;
    logic [1:0]    blue_q;
    logic          draw_q;
    logic          rr_q;
    logic          rw_q;
    logic          bw_q;
    logic [1:0]    red_d;
    logic [1:0]    blue_d;
    logic          crash_tick;

    always_comb begin
        red_d      = (red_q < WIN) ? red_q + 2'd1 : red_q;
        blue_d     = (blue_q < WIN) ? blue_q + 2'd1 : blue_q;
        crash_tick = tick && (red_crash || blue_crash);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cd_q    <= '0;
            red_q   <= '0;
            blue_q  <= '0;
            draw_q  <= 1'b0;
            rr_q    <= 1'b0;
            rw_q    <= 1'b0;
            bw_q    <= 1'b0;
        end else begin
            rr_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start_ev) begin
                        state_q <= S_COUNT;
                        cnt_q   <= '0;
                        cd_q    <= CD_INIT;
                        draw_q  <= 1'b0;
                        rr_q    <= 1'b1;
                    end
                end
                S_COUNT: begin
                    if (tick) begin
                        if (cnt_q == SEC_LAST) begin
                            cnt_q <= '0;
                            if (cd_q == 2'd1) begin
                                state_q <= S_PLAY;
                                cd_q    <= 2'd0;
                            end else begin
                                cd_q <= cd_q - 2'd1;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                end
                S_PLAY: begin
                    if (crash_tick) begin
                        state_q <= S_CRASH;
                        cnt_q   <= '0;
                        if (red_crash && blue_crash) begin
                            draw_q <= 1'b1;
                        end else if (red_crash) begin
                            blue_q <= blue_d;
                        end else begin
                            red_q <= red_d;
                        end
                    end else if (pause_ev) begin
                        state_q <= S_PAUSE;
                        cnt_q   <= '0;
                    end
                end
                S_PAUSE: begin
                    if (pause_ev) begin
                        state_q <= S_PLAY;
                        cnt_q   <= '0;
                    end
                end
                S_CRASH: begin
                    if (tick) begin
                        if (cnt_q == HOLD_LAST) begin
                            cnt_q <= '0;
                            if (red_q == WIN || blue_q == WIN) begin
                                state_q <= S_OVER;
                                rw_q    <= (red_q == WIN);
                                bw_q    <= (blue_q == WIN);
                            end else begin
                                state_q <= S_COUNT;
                                cd_q    <= CD_INIT;
                                draw_q  <= 1'b0;
                                rr_q    <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                end
                S_OVER: begin
                    if (start_ev) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                        red_q   <= '0;
                        blue_q  <= '0;
                        draw_q  <= 1'b0;
                        rw_q    <= 1'b0;
                        bw_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign game_state    = state_q;
    assign reset_round   = rr_q;
    assign score_red     = red_q;
    assign score_blue    = blue_q;
    assign countdown_sec = cd_q;
    assign Red_W         = rw_q;
    assign Blue_W        = bw_q;
    assign draw_round    = draw_q;

endmodule

// File: tb/tb_round_controller.sv
// tb_round_controller: randomized scenarios for round_controller
// checked against a rule-level match model.
module tb_round_controller;

    localparam int FPS  = 2;
    localparam int CDS  = 3;
    localparam int HOLD = 2;
    localparam int WIN  = 3;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_clk = 1'b0;
    logic       start_btn = 1'b0;
    logic       pause_btn = 1'b0;
    logic       red_crash = 1'b0;
    logic       blue_crash = 1'b0;
    logic [2:0] game_state;
    logic       reset_round;
    logic [1:0] score_red;
    logic [1:0] score_blue;
    logic [1:0] countdown_sec;
    logic       Red_W;
    logic       Blue_W;
    logic       draw_round;

    int total = 0;
    int bad = 0;

    always #10 Clk = ~Clk;

    round_controller #(
        .WIN_SCORE(WIN),
        .FRAMES_PER_SEC(FPS),
        .COUNTDOWN_SECS(CDS),
        .CRASH_HOLD_FRAMES(HOLD)
    ) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .frame_clk(frame_clk),
        .start_btn(start_btn),
        .pause_btn(pause_btn),
        .red_crash(red_crash),
        .blue_crash(blue_crash),
        .game_state(game_state),
        .reset_round(reset_round),
        .score_red(score_red),
        .score_blue(score_blue),
        .countdown_sec(countdown_sec),
        .Red_W(Red_W),
        .Blue_W(Blue_W),
        .draw_round(draw_round)
    );

    // Match model: phase, scores, draw flag, ticks spent in countdown/hold.
    int m_st, m_red, m_blue, m_draw, m_cdt, m_hold, m_rr;

    logic [12:0] o_vec;
    logic        o_rr2;

    task automatic model_reset();
        m_st = 0; m_red = 0; m_blue = 0; m_draw = 0;
        m_cdt = 0; m_hold = 0; m_rr = 0;
    endtask

    task automatic model(input int which, input logic rc, input logic bc);
        bit tk, st, ps;
        tk = (which == 0 || which == 3);
        st = (which == 1);
        ps = (which == 2 || which == 3);
        m_rr = 0;
        case (m_st)
            0: if (st) begin
                m_st = 1; m_cdt = 0; m_draw = 0; m_rr = 1;
            end
            1: if (tk) begin
                m_cdt++;
                if (m_cdt == CDS * FPS) m_st = 2;
            end
            2: if (tk && (rc || bc)) begin
                m_st = 4; m_hold = 0;
                if (rc && bc) m_draw = 1;
                else if (rc) m_blue = (m_blue < WIN) ? m_blue + 1 : m_blue;
                else m_red = (m_red < WIN) ? m_red + 1 : m_red;
            end else if (ps) begin
                m_st = 3;
            end
            3: if (ps) m_st = 2;
            4: if (tk) begin
                m_hold++;
                if (m_hold == HOLD) begin
                    if (m_red == WIN || m_blue == WIN) begin
                        m_st = 5;
                    end else begin
                        m_st = 1; m_cdt = 0; m_draw = 0; m_rr = 1;
                    end
                end
            end
            5: if (st) begin
                m_st = 0; m_red = 0; m_blue = 0; m_draw = 0;
            end
            default: m_st = 0;
        endcase
    endtask

    function automatic logic [12:0] exp_vec();
        int cd;
        cd = (m_st == 1) ? CDS - m_cdt / FPS : 0;
        return {3'(m_st), 1'(m_rr), 2'(m_red), 2'(m_blue), 2'(cd),
                1'(m_st == 5 && m_red == WIN),
                1'(m_st == 5 && m_blue == WIN), 1'(m_draw)};
    endfunction

    function automatic logic [12:0] cur_vec();
        return {game_state, reset_round, score_red, score_blue,
                countdown_sec, Red_W, Blue_W, draw_round};
    endfunction

    // which: 0 frame tick, 1 start, 2 pause, 3 tick+pause together
    task automatic fire(input int which, input logic rc, input logic bc);
        @(negedge Clk);
        red_crash = rc;
        blue_crash = bc;
        case (which)
            0: frame_clk = 1'b1;
            1: start_btn = 1'b1;
            2: pause_btn = 1'b1;
            default: begin
                frame_clk = 1'b1;
                pause_btn = 1'b1;
            end
        endcase
        repeat (4) @(posedge Clk);
        #1;
        o_vec = cur_vec();
        @(posedge Clk);
        #1;
        o_rr2 = reset_round;
        @(negedge Clk);
        frame_clk = 1'b0; start_btn = 1'b0; pause_btn = 1'b0;
        red_crash = 1'b0; blue_crash = 1'b0;
        model(which, rc, bc);
        repeat ($urandom_range(2, 4)) @(negedge Clk);
    endtask

    task automatic run_to_play();
        repeat (FPS * CDS) fire(0, 1'b0, 1'b0);
    endtask

    task automatic hold_out();
        repeat (HOLD) fire(0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        total++;
        if (cur_vec() !== 13'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 0", cur_vec());
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        model_reset();
        repeat (5) @(negedge Clk);
        total++;
        if (cur_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL post_reset_idle: got %b want %b", cur_vec(), exp_vec());
        end
    endtask

    task automatic test_start();
        int n;
        logic rr_first, rr_next;
        logic [1:0] cd_first;
        n = 0;
        @(negedge Clk);
        start_btn = 1'b1;
        while (n < 20) begin
            @(posedge Clk);
            #1;
            n++;
            if (game_state == 3'd1) break;
        end
        rr_first = reset_round;
        cd_first = countdown_sec;
        @(posedge Clk);
        #1;
        rr_next = reset_round;
        @(negedge Clk);
        start_btn = 1'b0;
        model(1, 1'b0, 1'b0);
        total++;
        if (n !== 4) begin
            bad++;
            $display("FAIL start_latency: got %0d cycles want 4", n);
        end
        total++;
        if (rr_first !== 1'b1 || rr_next !== 1'b0) begin
            bad++;
            $display("FAIL start_reset_round: got %b%b want 10", rr_first, rr_next);
        end
        total++;
        if (cd_first !== 2'd3) begin
            bad++;
            $display("FAIL start_countdown: got %0d want 3", cd_first);
        end
        repeat (3) @(negedge Clk);
    endtask

    task automatic test_countdown();
        logic [12:0] e;
        for (int i = 0; i < FPS * CDS; i++) begin
            e = exp_vec();
            total++;
            if (countdown_sec !== e[4:3]) begin
                bad++;
                $display("FAIL countdown_step%0d: got %0d want %0d", i, countdown_sec, e[4:3]);
            end
            if ($urandom_range(0, 1) == 1)
                fire($urandom_range(1, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            fire(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        total++;
        if (o_vec[12:10] !== 3'd2 || o_vec[4:3] !== 2'd0) begin
            bad++;
            $display("FAIL countdown_to_play: got st=%0d cd=%0d want st=2 cd=0", o_vec[12:10], o_vec[4:3]);
        end
        total++;
        if (o_vec !== exp_vec()) begin
            bad++;
            $display("FAIL countdown_outputs: got %b want %b", o_vec, exp_vec());
        end
    endtask

    task automatic test_red_wins();
        for (int r = 1; r <= 3; r++) begin
            fire(0, 1'b0, 1'b1);
            total++;
            if (o_vec[12:10] !== 3'd4 || o_vec[8:7] !== 2'(r) || o_vec[6:5] !== 2'd0) begin
                bad++;
                $display("FAIL red_round%0d_score: got st=%0d red=%0d blue=%0d want 4/%0d/0", r, o_vec[12:10], o_vec[8:7], o_vec[6:5], r);
            end
            hold_out();
            total++;
            if (o_vec !== exp_vec() || o_rr2 !== 1'b0) begin
                bad++;
                $display("FAIL red_round%0d_hold: got %b rr2=%b want %b rr2=0", r, o_vec, o_rr2, exp_vec());
            end
            total++;
            if (o_vec[9] !== (r < 3)) begin
                bad++;
                $display("FAIL red_round%0d_reset_round: got %b want %b", r, o_vec[9], r < 3);
            end
            if (r < 3) run_to_play();
        end
        total++;
        if (o_vec[12:10] !== 3'd5 || o_vec[2:1] !== 2'b10) begin
            bad++;
            $display("FAIL red_match_over: got st=%0d W=%b want st=5 W=10", o_vec[12:10], o_vec[2:1]);
        end
        fire(1, 1'b0, 1'b0);
        total++;
        if (o_vec !== 13'd0 || o_vec !== exp_vec()) begin
            bad++;
            $display("FAIL red_back_to_idle: got %b want 0", o_vec);
        end
    endtask

    task automatic test_draw();
        fire(1, 1'b0, 1'b0);
        run_to_play();
        fire(0, 1'b1, 1'b0);
        hold_out();
        run_to_play();
        fire(0, 1'b0, 1'b1);
        hold_out();
        run_to_play();
        fire(0, 1'b1, 1'b1);
        total++;
        if (o_vec[12:10] !== 3'd4 || o_vec[0] !== 1'b1 || o_vec[8:5] !== 4'b0101) begin
            bad++;
            $display("FAIL draw_crash: got st=%0d draw=%b scores=%b want 4/1/0101", o_vec[12:10], o_vec[0], o_vec[8:5]);
        end
        hold_out();
        total++;
        if (o_vec[12:10] !== 3'd1 || o_vec[0] !== 1'b0 || o_vec[9] !== 1'b1) begin
            bad++;
            $display("FAIL draw_clear: got st=%0d draw=%b rr=%b want 1/0/1", o_vec[12:10], o_vec[0], o_vec[9]);
        end
        run_to_play();
        total++;
        if (o_vec !== exp_vec()) begin
            bad++;
            $display("FAIL draw_next_play: got %b want %b", o_vec, exp_vec());
        end
    endtask

    task automatic test_pause();
        logic [1:0] f;
        fire(2, 1'b0, 1'b0);
        total++;
        if (o_vec[12:10] !== 3'd3) begin
            bad++;
            $display("FAIL pause_enter: got %0d want 3", o_vec[12:10]);
        end
        for (int i = 0; i < 4; i++) begin
            f = 2'($urandom_range(1, 3));
            fire(0, f[1], f[0]);
            total++;
            if (o_vec[12:10] !== 3'd3 || o_vec[8:5] !== 4'b0101) begin
                bad++;
                $display("FAIL pause_frozen%0d: got st=%0d scores=%b want 3/0101", i, o_vec[12:10], o_vec[8:5]);
            end
        end
        fire(1, 1'b0, 1'b0);
        total++;
        if (o_vec !== exp_vec()) begin
            bad++;
            $display("FAIL pause_start_ignored: got %b want %b", o_vec, exp_vec());
        end
        fire(2, 1'b0, 1'b0);
        total++;
        if (o_vec[12:10] !== 3'd2 || o_vec[9] !== 1'b0 || o_rr2 !== 1'b0) begin
            bad++;
            $display("FAIL pause_resume: got st=%0d rr=%b%b want 2/00", o_vec[12:10], o_vec[9], o_rr2);
        end
        f = 2'($urandom_range(1, 3));
        fire(3, f[1], f[0]);
        total++;
        if (o_vec[12:10] !== 3'd4 || o_vec !== exp_vec()) begin
            bad++;
            $display("FAIL pause_vs_crash: got %b want %b", o_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        int w;
        for (int i = 0; i < 120; i++) begin
            w = $urandom_range(0, 9);
            fire((w < 6) ? 0 : (w == 6) ? 1 : (w < 9) ? 2 : 3,
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
            total++;
            if (o_vec !== exp_vec()) begin
                bad++;
                $display("FAIL random_step%0d: got %b want %b", i, o_vec, exp_vec());
            end
            total++;
            if (o_rr2 !== 1'b0) begin
                bad++;
                $display("FAIL random_rr_width%0d: got %b want 0", i, o_rr2);
            end
        end
    endtask

    task automatic test_midreset();
        int stray;
        @(negedge Clk);
        Reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (5) @(negedge Clk);
        fire(1, 1'b0, 1'b0);
        run_to_play();
        fire(0, 1'b1, 1'b0);
        hold_out();
        run_to_play();
        fire(0, 1'b1, 1'b0);
        total++;
        if (o_vec[12:10] !== 3'd4 || o_vec[6:5] !== 2'd2) begin
            bad++;
            $display("FAIL midreset_setup: got st=%0d blue=%0d want 4/2", o_vec[12:10], o_vec[6:5]);
        end
        @(negedge Clk);
        start_btn = 1'b1;
        #3;
        Reset_n = 1'b0;
        #1;
        total++;
        if (cur_vec() !== 13'd0) begin
            bad++;
            $display("FAIL midreset_async: got %b want 0", cur_vec());
        end
        model_reset();
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge Clk);
            #1;
            if (cur_vec() !== 13'd0) stray++;
        end
        total++;
        if (stray !== 0) begin
            bad++;
            $display("FAIL midreset_held_start: got %0d active cycles want 0", stray);
        end
        @(negedge Clk);
        start_btn = 1'b0;
        repeat (3) @(negedge Clk);
        fire(1, 1'b0, 1'b0);
        total++;
        if (o_vec !== exp_vec() || o_vec[9] !== 1'b1) begin
            bad++;
            $display("FAIL midreset_restart: got %b want %b", o_vec, exp_vec());
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_start();
        test_countdown();
        test_red_wins();
        test_draw();
        test_pause();
        test_random();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
